// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences the 1-D convolution z[i] = sum_j x[j]*y[i-j].
// It issues X/Y read addresses to synchronous-read memories, accumulates
// the returned products and writes one Z sample per output index.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start_in               launch request (only looked at in IDLE)
//   size_x_in, size_y_in   vector lengths, latched on an accepted start
//   x_data_in, y_data_in   memory read data, one cycle after the address
//   x_addr_out, y_addr_out X/Y read addresses
//   z_addr_out, z_data_out Z write address/data, z_we_out write strobe
//   busy_out, done_out     status back to the register interface
module conv_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_in,
  input  logic [ADDR_WIDTH-1:0]                size_x_in,
  input  logic [ADDR_WIDTH-1:0]                size_y_in,
  input  logic [DATA_WIDTH-1:0]                x_data_in,
  input  logic [DATA_WIDTH-1:0]                y_data_in,
  output logic [ADDR_WIDTH-1:0]                x_addr_out,
  output logic [ADDR_WIDTH-1:0]                y_addr_out,
  output logic [ADDR_WIDTH:0]                  z_addr_out,
  output logic [2*DATA_WIDTH+ADDR_WIDTH-1:0]   z_data_out,
  output logic                                 z_we_out,
  output logic                                 busy_out,
  output logic                                 done_out
);

  localparam int unsigned Z_WIDTH     = 2 * DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned ZADDR_WIDTH = ADDR_WIDTH + 1;
  localparam int unsigned PROD_WIDTH  = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FETCH = 3'd2,
    ACC   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    sx_q, sx_d, sy_q, sy_d;
  logic [ZADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]    j_q, j_d, jmax_q, jmax_d;
  logic [Z_WIDTH-1:0]       acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]    x_addr_d, y_addr_d;
  logic [ZADDR_WIDTH-1:0]   z_addr_d;
  logic [Z_WIDTH-1:0]       z_data_d;
  logic                     z_we_d, busy_d, done_d;

  // Index window helpers, all in the wider output-index domain
  logic [ZADDR_WIDTH-1:0]   sx_m1, sy_m1, last_i, jmin_w, jmax_w, j_inc_w;
  logic [ADDR_WIDTH-1:0]    j_inc;
  logic [PROD_WIDTH-1:0]    prod;
  logic [Z_WIDTH-1:0]       acc_sum;

  always_comb begin
    sx_m1   = ZADDR_WIDTH'(sx_q) - ZADDR_WIDTH'(1);
    sy_m1   = ZADDR_WIDTH'(sy_q) - ZADDR_WIDTH'(1);
    last_i  = ZADDR_WIDTH'(sx_q) + ZADDR_WIDTH'(sy_q) - ZADDR_WIDTH'(2);
    jmin_w  = (i_q >= sy_m1) ? (i_q - sy_m1) : '0;
    jmax_w  = (i_q < sx_m1) ? i_q : sx_m1;
    j_inc   = j_q + ADDR_WIDTH'(1);
    j_inc_w = ZADDR_WIDTH'(j_inc);
    prod    = PROD_WIDTH'(x_data_in) * PROD_WIDTH'(y_data_in);
    acc_sum = acc_q + Z_WIDTH'(prod);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      jmax_q     <= '0;
      acc_q      <= '0;
      x_addr_out <= '0;
      y_addr_out <= '0;
      z_addr_out <= '0;
      z_data_out <= '0;
      z_we_out   <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      i_q        <= i_d;
      j_q        <= j_d;
      jmax_q     <= jmax_d;
      acc_q      <= acc_d;
      x_addr_out <= x_addr_d;
      y_addr_out <= y_addr_d;
      z_addr_out <= z_addr_d;
      z_data_out <= z_data_d;
      z_we_out   <= z_we_d;
      busy_out   <= busy_d;
      done_out   <= done_d;
    end
  end

  // Next state; outputs are computed for the state being entered so the
  // registered values line up with that state's cycle
  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    i_d      = i_q;
    j_d      = j_q;
    jmax_d   = jmax_q;
    acc_d    = acc_q;
    x_addr_d = x_addr_out;
    y_addr_d = y_addr_out;
    z_addr_d = z_addr_out;
    z_data_d = z_data_out;
    z_we_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        x_addr_d = '0;
        y_addr_d = '0;
        if (start_in) begin
          if ((size_x_in != '0) && (size_y_in != '0)) begin
            state_d = SETUP;
            sx_d    = size_x_in;
            sy_d    = size_y_in;
            i_d     = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        j_d      = ADDR_WIDTH'(jmin_w);
        jmax_d   = ADDR_WIDTH'(jmax_w);
        acc_d    = '0;
        x_addr_d = ADDR_WIDTH'(jmin_w);
        y_addr_d = ADDR_WIDTH'(i_q - jmin_w);
        state_d  = FETCH;
      end
      FETCH: begin
        state_d = ACC;
      end
      ACC: begin
        // Memory data here belongs to the address presented during FETCH
        acc_d = acc_sum;
        if (j_q == jmax_q) begin
          state_d  = WRITE;
          z_we_d   = 1'b1;
          z_addr_d = i_q;
          z_data_d = acc_sum;
        end else begin
          j_d      = j_inc;
          x_addr_d = j_inc;
          y_addr_d = ADDR_WIDTH'(i_q - j_inc_w);
          state_d  = FETCH;
        end
      end
      WRITE: begin
        if (i_q == last_i) begin
          state_d  = DONE;
          done_d   = 1'b1;
          x_addr_d = '0;
          y_addr_d = '0;
        end else begin
          i_d     = i_q + ZADDR_WIDTH'(1);
          state_d = SETUP;
        end
      end
      DONE: begin
        state_d  = IDLE;
        x_addr_d = '0;
        y_addr_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: synchronous-read X/Y memory models,
// directed scenarios plus randomized runs against a plain-loop convolution.
module tb_conv_sequencer;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int ZW  = 2 * DW + AW;
  localparam int ZAW = AW + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_in;
  logic [AW-1:0]  size_x_in, size_y_in;
  logic [DW-1:0]  x_data_in, y_data_in;
  logic [AW-1:0]  x_addr_out, y_addr_out;
  logic [ZAW-1:0] z_addr_out;
  logic [ZW-1:0]  z_data_out;
  logic           z_we_out, busy_out, done_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] xmem [32];
  logic [DW-1:0] ymem [32];

  int          wr_addr [$];
  longint      wr_data [$];
  longint      exp_z   [$];
  int          busy_cnt, done_cnt, first_busy, nz_addr;
  bit          timed_out;

  conv_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .size_x_in  (size_x_in),
    .size_y_in  (size_y_in),
    .x_data_in  (x_data_in),
    .y_data_in  (y_data_in),
    .x_addr_out (x_addr_out),
    .y_addr_out (y_addr_out),
    .z_addr_out (z_addr_out),
    .z_data_out (z_data_out),
    .z_we_out   (z_we_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of latency
  always @(posedge clk) begin
    x_data_in <= xmem[x_addr_out];
    y_data_in <= ymem[y_addr_out];
  end

  // Reference convolution straight from the definition
  task automatic model(input int sx, input int sy);
    longint s;
    exp_z.delete();
    if (sx == 0 || sy == 0) return;
    for (int i = 0; i <= sx + sy - 2; i++) begin
      s = 0;
      for (int j = 0; j < sx; j++)
        if (i - j >= 0 && i - j < sy) s += longint'(xmem[j]) * longint'(ymem[i - j]);
      exp_z.push_back(s);
    end
  endtask

  // Observe one run at falling edges until done_out, with a cycle budget
  task automatic wait_done(input bit hold, input bit scramble);
    busy_cnt = 0; done_cnt = 0; first_busy = -1; nz_addr = 0; timed_out = 1'b1;
    wr_addr.delete(); wr_data.delete();
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (!hold) start_in = 1'b0;
      if (scramble) begin
        size_x_in = AW'($urandom);
        size_y_in = AW'($urandom);
      end
      if (busy_out) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (x_addr_out != '0 || y_addr_out != '0) nz_addr++;
      if (z_we_out) begin
        wr_addr.push_back(int'(z_addr_out));
        wr_data.push_back(longint'(z_data_out));
      end
      if (done_out) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic launch(input int sx, input int sy, input bit hold, input bit scramble);
    @(negedge clk);
    size_x_in = AW'(sx);
    size_y_in = AW'(sy);
    start_in  = 1'b1;
    wait_done(hold, scramble);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; size_x_in = '0; size_y_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_out, done_out, z_we_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 000", {busy_out, done_out, z_we_out});
    end
    n_cmp++;
    if ({x_addr_out, y_addr_out, z_addr_out, z_data_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got x=%0d y=%0d za=%0d zd=%0d expected all 0",
                         x_addr_out, y_addr_out, z_addr_out, z_data_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy_out);
    end
  endtask

  task automatic test_basic();
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3; ymem[0] = 1; ymem[1] = 1;
    launch(3, 2, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || wr_addr.size() != 4) begin
      n_fail++; $display("FAIL basic_writes: got %0d writes (timeout %0d) expected 4", wr_addr.size(), timed_out);
    end else begin
      for (int k = 0; k < 4; k++) begin
        longint e;
        e = (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 5 : 3;
        n_cmp++;
        if (wr_addr[k] !== k || wr_data[k] !== e) begin
          n_fail++; $display("FAIL basic_z%0d: got addr %0d data %0d expected addr %0d data %0d",
                             k, wr_addr[k], wr_data[k], k, e);
        end
      end
    end
    n_cmp++;
    if (busy_cnt !== 21 || done_cnt !== 1 || first_busy !== 1) begin
      n_fail++; $display("FAIL basic_timing: got busy %0d done %0d first %0d expected 21 1 1",
                         busy_cnt, done_cnt, first_busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy_out, done_out, x_addr_out, y_addr_out} !== '0) begin
      n_fail++; $display("FAIL basic_after_done: got busy %b done %b x %0d y %0d expected all 0",
                         busy_out, done_out, x_addr_out, y_addr_out);
    end
  endtask

  task automatic test_single();
    xmem[0] = 5; ymem[0] = 7;
    launch(1, 1, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || wr_addr.size() != 1 || wr_addr[0] !== 0 || wr_data[0] !== 35) begin
      n_fail++; $display("FAIL single_write: got %0d writes first data %0d expected 1 write z[0]=35",
                         wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : -1);
    end
    n_cmp++;
    if (busy_cnt !== 5) begin
      n_fail++; $display("FAIL single_busy: got %0d expected 5", busy_cnt);
    end
  endtask

  task automatic test_zero_size();
    launch(0, 4, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || first_busy !== 1 || busy_cnt !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_timing: got first %0d busy %0d done %0d expected 1 1 1",
                         first_busy, busy_cnt, done_cnt);
    end
    n_cmp++;
    if (wr_addr.size() != 0 || nz_addr != 0) begin
      n_fail++; $display("FAIL zero_access: got %0d writes %0d nonzero addr cycles expected 0 0",
                         wr_addr.size(), nz_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy_out, done_out, z_we_out} !== 3'b000) begin
      n_fail++; $display("FAIL zero_after: got %b expected 000", {busy_out, done_out, z_we_out});
    end
  endtask

  task automatic test_max();
    for (int k = 0; k < 32; k++) begin xmem[k] = 8'hFF; ymem[k] = 8'hFF; end
    launch(31, 31, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || wr_addr.size() != 61) begin
      n_fail++; $display("FAIL max_count: got %0d writes expected 61", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_data[0] !== 65025 || wr_data[30] !== 2015775 || wr_data[60] !== 65025) begin
        n_fail++; $display("FAIL max_values: got %0d %0d %0d expected 65025 2015775 65025",
                           wr_data[0], wr_data[30], wr_data[60]);
      end
    end
    n_cmp++;
    if (busy_cnt !== 2 * 31 * 31 + 2 * 61 + 1) begin
      n_fail++; $display("FAIL max_busy: got %0d expected %0d", busy_cnt, 2 * 31 * 31 + 2 * 61 + 1);
    end
  endtask

  task automatic test_start_held();
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3; ymem[0] = 1; ymem[1] = 1;
    launch(3, 2, 1'b1, 1'b0);
    n_cmp++;
    if (timed_out || done_cnt !== 1 || busy_cnt !== 21 || wr_addr.size() != 4) begin
      n_fail++; $display("FAIL held_run: got done %0d busy %0d writes %0d expected 1 21 4",
                         done_cnt, busy_cnt, wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_data[0] !== 1 || wr_data[1] !== 3 || wr_data[2] !== 5 || wr_data[3] !== 3) begin
        n_fail++; $display("FAIL held_data: got %0d %0d %0d %0d expected 1 3 5 3",
                           wr_data[0], wr_data[1], wr_data[2], wr_data[3]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy_out !== 1'b0) begin
      n_fail++; $display("FAIL held_idle_gap: got busy %b expected 0", busy_out);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_out !== 1'b1) begin
      n_fail++; $display("FAIL held_restart: got busy %b expected 1", busy_out);
    end
    start_in = 1'b0;
    wait_done(1'b0, 1'b1);
    n_cmp++;
    if (timed_out || wr_addr.size() != 4 || wr_data[3] !== 3 || busy_cnt !== 20) begin
      n_fail++; $display("FAIL held_second: got writes %0d busy %0d expected 4 20", wr_addr.size(), busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin xmem[k] = 8'(k + 1); ymem[k] = 1; end
    @(negedge clk);
    size_x_in = 4; size_y_in = 4; start_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_in = 1'b0;
    end
    n_cmp++;
    if (busy_out !== 1'b1 || x_addr_out !== 1 || y_addr_out !== 0 || z_data_out !== 1) begin
      n_fail++; $display("FAIL mid_before_rst: got busy %b x %0d y %0d zd %0d expected 1 1 0 1",
                         busy_out, x_addr_out, y_addr_out, z_data_out);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_out, done_out, z_we_out, x_addr_out, y_addr_out, z_addr_out, z_data_out} !== '0) begin
      n_fail++; $display("FAIL mid_rst_outputs: got busy %b x %0d y %0d za %0d zd %0d expected all 0",
                         busy_out, x_addr_out, y_addr_out, z_addr_out, z_data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    xmem[0] = 1; xmem[1] = 2; ymem[0] = 3; ymem[1] = 4;
    launch(2, 2, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || wr_addr.size() != 3) begin
      n_fail++; $display("FAIL mid_rerun_count: got %0d writes expected 3", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_data[0] !== 3 || wr_data[1] !== 10 || wr_data[2] !== 8 || wr_addr[2] !== 2) begin
        n_fail++; $display("FAIL mid_rerun_data: got %0d %0d %0d expected 3 10 8",
                           wr_data[0], wr_data[1], wr_data[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int sx, sy, eb;
      sx = (r == 3) ? 0 : $urandom_range(1, 9);
      sy = (r == 5) ? 0 : $urandom_range(1, 9);
      for (int k = 0; k < 32; k++) begin
        xmem[k] = 8'($urandom_range(0, 255));
        ymem[k] = 8'($urandom_range(0, 255));
      end
      model(sx, sy);
      eb = (sx == 0 || sy == 0) ? 1 : 2 * sx * sy + 2 * (sx + sy - 1) + 1;
      launch(sx, sy, 1'b0, 1'b1);
      n_cmp++;
      if (timed_out || busy_cnt !== eb || done_cnt !== 1 || wr_addr.size() != exp_z.size()) begin
        n_fail++; $display("FAIL rand%0d_shape (%0dx%0d): got busy %0d done %0d writes %0d expected %0d 1 %0d",
                           r, sx, sy, busy_cnt, done_cnt, wr_addr.size(), eb, exp_z.size());
      end else begin
        for (int k = 0; k < exp_z.size(); k++) begin
          n_cmp++;
          if (wr_addr[k] !== k || wr_data[k] !== exp_z[k]) begin
            n_fail++; $display("FAIL rand%0d_z%0d: got addr %0d data %0d expected addr %0d data %0d",
                               r, k, wr_addr[k], wr_data[k], k, exp_z[k]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin xmem[k] = '0; ymem[k] = '0; end
    test_reset();
    test_basic();
    test_single();
    test_zero_size();
    test_max();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
